// File: rtl/dedisp_pkg.sv
// Shared constants, FSM state type and the saturating add helper for the
// dedispersion power accumulator.
package dedisp_pkg;

    localparam int IN_W         = 16;
    localparam int ACC_W        = 24;
    localparam int TS_W         = 40;
    localparam int HOLD_DEFAULT = 16;
    localparam int LEN_W        = 11;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Unsigned add of a zero-extended sample that clamps at all-ones.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [IN_W-1:0]  x);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, x};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/dedisp_power_accum_if.sv
// Sample stream in, published frame results out.
// Optional macro DEDISP_ACC_SAT_EN adds the sat_flag result bit.
interface dedisp_power_accum_if;
    import dedisp_pkg::*;

    logic             en;
    logic [LEN_W-1:0] frame_len;
    logic [IN_W-1:0]  power_in;
    logic             power_valid;
    logic [ACC_W-1:0] power_com;
    logic [TS_W-1:0]  timer_flag;
    logic             dready;
    logic [15:0]      frame_cnt;
    logic             busy;
`ifdef DEDISP_ACC_SAT_EN
    logic             sat_flag;
`endif

    modport master (
        output en, frame_len, power_in, power_valid,
        input  power_com, timer_flag, dready, frame_cnt, busy
`ifdef DEDISP_ACC_SAT_EN
        , input sat_flag
`endif
    );

    modport slave (
        input  en, frame_len, power_in, power_valid,
        output power_com, timer_flag, dready, frame_cnt, busy
`ifdef DEDISP_ACC_SAT_EN
        , output sat_flag
`endif
    );

endinterface

// File: rtl/dedisp_hold_pulse.sv
// Stretches a one-cycle load strobe into a pulse exactly HOLD cycles long.
module dedisp_hold_pulse
    import dedisp_pkg::*;
#(
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic pulse
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [CW-1:0] cnt;

    // Load HOLD-1 on a strobe, count down while high, drop one cycle after zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            pulse <= 1'b1;
            cnt   <= CW'(HOLD - 1);
        end else if (pulse) begin
            if (cnt == '0)
                pulse <= 1'b0;
            else
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/dedisp_power_accum.sv
// Frame integrator for dedispersed power: sums accepted samples over a
// programmable frame, then publishes the sum, the first-sample timestamp and a
// HOLD-cycle dready pulse. Published outputs stay put until the next publish.
// Optional macro DEDISP_ACC_SAT_EN: saturating sum plus sat_flag output.
module dedisp_power_accum
    import dedisp_pkg::*;
#(
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    dedisp_power_accum_if.slave  bus
);

    // Frames never shorter than HOLD+1 so dready always falls before the next publish.
    localparam int MIN_LEN = HOLD + 1;
    localparam int CNT_W   = (LEN_W > $clog2(MIN_LEN + 1)) ? LEN_W : $clog2(MIN_LEN + 1);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, sum_nxt;
    logic [CNT_W-1:0] cnt, len_q, len_eff;
    logic [TS_W-1:0]  ts, ts_start;
    logic             accept, start, abort, publish;

    assign accept  = bus.power_valid && bus.en;
    assign len_eff = (CNT_W'(bus.frame_len) < CNT_W'(MIN_LEN)) ? CNT_W'(MIN_LEN)
                                                                : CNT_W'(bus.frame_len);

    // acc is zero in IDLE, so one adder serves both frame start and accumulate.
`ifdef DEDISP_ACC_SAT_EN
    logic ovf, sat_q;
    assign ovf     = ACC_W'(bus.power_in) > ~acc;
    assign sum_nxt = sat_add(acc, bus.power_in);
`else
    assign sum_nxt = acc + ACC_W'(bus.power_in);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: enter ACC on a first sample, leave on the last sample or en drop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACC;
            ACC:     if (abort || publish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: frame start / discard / publish strobes and busy.
    always_comb begin
        start    = 1'b0;
        abort    = 1'b0;
        publish  = 1'b0;
        bus.busy = (state == ACC);
        case (state)
            IDLE: start = accept;
            ACC: begin
                abort   = !bus.en;
                publish = accept && ((cnt + CNT_W'(1)) == len_q);
            end
            default: ;
        endcase
    end

    // Running sum, sample count, frame length and first-sample timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            ts_start <= '0;
        end else if (start) begin
            acc      <= sum_nxt;
            cnt      <= CNT_W'(1);
            len_q    <= len_eff;
            ts_start <= ts;
        end else if (abort || publish) begin
            acc <= '0;
            cnt <= '0;
        end else if ((state == ACC) && accept) begin
            acc <= sum_nxt;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Free-running sample timestamp, advanced on every accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ts <= '0;
        else if (accept)
            ts <= ts + TS_W'(1);
    end

`ifdef DEDISP_ACC_SAT_EN
    // Sticky overflow marker for the frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_q <= 1'b0;
        else if (start)
            sat_q <= ovf;
        else if (abort || publish)
            sat_q <= 1'b0;
        else if ((state == ACC) && accept)
            sat_q <= sat_q || ovf;
    end
`endif

    // Published results, held until the next publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.power_com  <= '0;
            bus.timer_flag <= '0;
            bus.frame_cnt  <= '0;
`ifdef DEDISP_ACC_SAT_EN
            bus.sat_flag   <= 1'b0;
`endif
        end else if (publish) begin
`ifdef DEDISP_ACC_SAT_EN
            bus.power_com  <= (sat_q || ovf) ? {ACC_W{1'b1}} : sum_nxt;
            bus.sat_flag   <= sat_q || ovf;
`else
            bus.power_com  <= sum_nxt;
`endif
            bus.timer_flag <= ts_start;
            bus.frame_cnt  <= bus.frame_cnt + 16'd1;
        end
    end

    dedisp_hold_pulse #(.HOLD(HOLD)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (publish),
        .pulse (bus.dready)
    );

endmodule

// File: doc/dedisp_power_accum.md
Name: dedisp_power_accum

Overview:
- Upstream neighbour of the dedispersion FIFO packer.
- Integrates a stream of dedispersed per-sample power values over a programmable frame length.
- At each frame end, publishes a 24-bit power sum (power_com), the 40-bit sample timestamp of the frame's first sample (timer_flag), and a held dready pulse.
- The packer detects the dready rising edge and reads power_com/timer_flag live for about 11 clk cycles afterwards. Those outputs must therefore stay stable until the next frame is published.

Parameters:
- IN_W, 16: width of power_in.
- ACC_W, 24: width of the published power sum.
- TS_W, 40: width of the sample timestamp counter.
- HOLD, 16: clk cycles dready stays high after publish.
- LEN_W, 11: width of the frame-length input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  accumulation enable
- frame_len  in  LEN_W  samples per frame; sampled at frame start
- power_in  in  IN_W  unsigned dedispersed power sample
- power_valid  in  1  power_in qualifier
- power_com  out  ACC_W  published frame sum
- timer_flag  out  TS_W  timestamp of the first sample of the published frame
- dready  out  1  frame-ready flag, high for HOLD cycles
- frame_cnt  out  16  published-frame counter, wraps
- busy  out  1  high while state == ACC

Behaviour:
- Reset is asynchronous, active-high. While rst is asserted, every register is 0: power_com, timer_flag, dready, frame_cnt, busy, the accumulator, the sample counter, the timestamp counter and the hold counter. State = IDLE.
- Accepted sample: a cycle with power_valid && en.
- Timestamp counter ts: increments by 1 on every accepted sample and wraps modulo 2^TS_W.
- Effective length: L = max(frame_len, HOLD+1), latched when a frame starts. This guarantees dready falls before the next publish, so every frame produces a rising edge.
- State IDLE:
  - acc = 0, cnt = 0.
  - On an accepted sample: acc <= power_in; cnt <= 1; ts_start <= ts; latch L; go to ACC.
- State ACC:
  - On an accepted sample: acc <= acc + power_in (see width rules); cnt <= cnt + 1.
  - When the accepted sample is the L-th of the frame, publish at the next edge:
    - power_com <= final sum (including this sample)
    - timer_flag <= ts_start
    - dready <= 1; hold counter <= HOLD-1
    - frame_cnt <= frame_cnt + 1
    - acc and cnt are cleared; state goes to IDLE. The next accepted sample starts a new frame with no dead cycle.
  - If en goes low: the partial frame is discarded (acc, cnt cleared) and state goes to IDLE. power_com, timer_flag and dready are unaffected.
- Latency: 1 clk from the edge that accepts the L-th sample to dready=1 with the new power_com/timer_flag.
- Hold: the hold counter decrements each cycle while dready=1. dready clears in the cycle after the counter reaches 0, so dready is high for exactly HOLD cycles. power_com and timer_flag hold until the next publish.
- Width rules: power_in is zero-extended. The accumulator is ACC_W bits wide; overflow handling is set by the optional feature below.
- Frame length limits: frame_len = 0 or any value ≤ HOLD is treated as HOLD+1. A frame_len change mid-frame takes effect at the next frame start.
- Simultaneous publish while dready is still high cannot occur, by the L rule.
- Reset mid-frame: everything clears immediately. The partial frame is never published.

Optional Feature:
- Macro: DEDISP_ACC_SAT_EN.
- Defined: the add saturates at 2^ACC_W-1. A sticky internal flag forces power_com to all-ones for that frame. An extra output port sat_flag (1 bit) mirrors the flag, latched with power_com at publish and cleared on the next publish or reset.
- Undefined: the add wraps modulo 2^ACC_W, and the sat_flag port does not exist.

Decomposition:
- Shared package dedisp_pkg holds:
  - constants IN_W, ACC_W, TS_W, HOLD_DEFAULT, LEN_W
  - state enum {IDLE, ACC}
  - a function sat_add(acc, x)
- One natural sub-module: dedisp_hold_pulse, the HOLD-cycle dready stretcher (load, count down, output). It is reusable wherever packer strobes need stretching.

Test Plan:
1. Reset then frame_len=20, en=1, power_in=100 valid every cycle:
   - dready rises 1 clk after sample 20, with power_com=2000 and timer_flag=0.
   - dready stays high exactly 16 cycles.
   - The second frame gives timer_flag=20, frame_cnt=2.
2. frame_len=5 (below HOLD+1), same stimulus:
   - Frames are 17 samples; power_com=1700.
   - dready falls before each next publish; every rise is separated by ≥1 low cycle.
3. Gapped valid (valid every 3rd cycle), frame_len=20, power_in=7:
   - power_com=140.
   - power_com/timer_flag remain stable across the whole 16-cycle dready window.
4. en dropped after sample 10 of a frame, then raised:
   - No publish for the partial frame.
   - The next frame sums only new samples; timer_flag equals ts at the restart sample.
5. power_in=65535, frame_len=300:
   - With DEDISP_ACC_SAT_EN: power_com=16777215 and sat_flag=1.
   - Without it: power_com = (300×65535) mod 2^24 = 2883284.
6. Assert rst mid-frame and while dready is high:
   - All outputs go to 0 asynchronously, before the next clk edge.
   - After release, the first frame's timer_flag=0.
